// File: rtl/mlp_pkg.sv
// Shared MLP definitions: FSM state encoding, constant clog2 helper, and the
// saturation / offset-binary conversion used by every MLP output stage.
package mlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } mlp_state_e;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // Two's complement to offset binary: flip the MSB of the w-bit word.
  // Callers keep only the low w bits of the result.
  function automatic logic signed [63:0] to_offset_binary(input logic signed [63:0] v, input int w);
    return v ^ (64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_saturate.sv
// Combinational post-processing of a MAC accumulator: drop the fractional
// bits (arithmetic shift, rounds toward -inf), saturate to DATA_WIDTH and
// convert to offset binary.
module mac_saturate
  import mlp_pkg::*;
#(
  parameter int ACC_W      = 22,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = DATA_WIDTH / 2
) (
  input  logic [ACC_W-1:0]      i_acc,
  output logic [DATA_WIDTH-1:0] o_sum
);

  logic signed [63:0] w_acc_ext;
  logic signed [63:0] w_shr;
  logic signed [63:0] w_sat;

  assign w_acc_ext = 64'($signed(i_acc));
  assign w_shr     = w_acc_ext >>> FRAC_BITS;
  assign w_sat     = saturate(w_shr, DATA_WIDTH);
  assign o_sum     = DATA_WIDTH'(to_offset_binary(w_sat, DATA_WIDTH));

endmodule

// File: rtl/neuron_mac_serial.sv
// Serial multiply-accumulate neuron core. Bias is latched on start, then
// INPUT_NUMBER (data, weight) pairs are accumulated one per transfer, and the
// saturated offset-binary sum is held on o_sum_out until accepted.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds its payload stable while valid is high and ready
// is low, and ready never depends combinationally on valid.
module neuron_mac_serial
  import mlp_pkg::*;
#(
  parameter int INPUT_NUMBER = 32,
  parameter int DATA_WIDTH   = 8,
  parameter int FRAC_BITS    = DATA_WIDTH / 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_bias_in,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [DATA_WIDTH-1:0] i_weight_in,
  output logic [DATA_WIDTH-1:0] o_sum_out,
  output logic                  o_sum_valid,
  input  logic                  i_sum_ready,
  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = (clog2(INPUT_NUMBER) < 1) ? 1 : clog2(INPUT_NUMBER);
  localparam int ACC_W  = 2 * DATA_WIDTH + clog2(INPUT_NUMBER) + 1;

  mlp_state_e              r_state;
  mlp_state_e              w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_sum_out;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [DATA_WIDTH-1:0]    w_sum_next;
  logic                     w_transfer;
  logic                     w_last;

  assign w_prod     = PROD_W'($signed(i_data_in)) * PROD_W'($signed(i_weight_in));
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_bias_ext = ACC_W'($signed(i_bias_in)) <<< FRAC_BITS;
  assign w_acc_next = r_acc + w_prod_ext;
  assign w_transfer = (r_state == ST_ACC) && i_in_valid;
  assign w_last     = w_transfer && (r_cnt == CNT_W'(INPUT_NUMBER - 1));

  // Result is formed from the accumulator value including the final pair,
  // so it can be registered on the same edge that enters OUT.
  mac_saturate #(
    .ACC_W      (ACC_W),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac_saturate (
    .i_acc (w_acc_next),
    .o_sum (w_sum_next)
  );

  // State register; reset discards any neuron in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start)     w_state_next = ST_ACC;
      ST_ACC:  if (w_last)      w_state_next = ST_OUT;
      ST_OUT:  if (i_sum_ready) w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    o_in_ready  = 1'b0;
    o_sum_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      ST_IDLE: o_busy      = 1'b0;
      ST_ACC:  o_in_ready  = 1'b1;
      ST_OUT:  o_sum_valid = 1'b1;
      default: o_busy      = 1'b0;
    endcase
  end

  // Datapath: bias load, accumulation, pair counter and registered result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sum_out <= '0;
    end else begin
      if (r_state == ST_IDLE && i_start) begin
        r_acc <= w_bias_ext;
        r_cnt <= '0;
      end else if (w_transfer) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_sum_out <= w_sum_next;
      end
    end
  end

  assign o_sum_out   = r_sum_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_neuron_mac_serial.sv
// Directed bench for neuron_mac_serial with INPUT_NUMBER=4, 8-bit Q4.4 data.
// Expected sums come from an integer reference model and flow through a
// queue from the point a neuron is started to the point its result is taken.
module tb_neuron_mac_serial;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int FB = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] bias_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic [DW-1:0] weight_in;
  logic [DW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]        exp_q[$];
  logic signed [DW-1:0] g_d[N];
  logic signed [DW-1:0] g_w[N];

  neuron_mac_serial #(
    .INPUT_NUMBER (N),
    .DATA_WIDTH   (DW),
    .FRAC_BITS    (FB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_bias_in   (bias_in),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_data_in   (data_in),
    .i_weight_in (weight_in),
    .o_sum_out   (sum_out),
    .o_sum_valid (sum_valid),
    .i_sum_ready (sum_ready),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bias<<FB plus full products, floor shift, clamp, +128 offset.
  function automatic logic [DW-1:0] model(input int bias);
    int acc;
    int r;
    acc = bias * 16;
    for (int i = 0; i < N; i++) acc += int'(g_d[i]) * int'(g_w[i]);
    r = acc >>> FB;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return DW'(r + 128);
  endfunction

  task automatic set_pairs(input int d, input int w);
    for (int i = 0; i < N; i++) begin
      g_d[i] = DW'(d);
      g_w[i] = DW'(w);
    end
  endtask

  // Driver: one full neuron. Inputs change and outputs are sampled on negedge.
  task automatic run_neuron(input string tag, input int bias, input bit gaps,
                            input int hold, input bit start_busy, input bit start_ack);
    logic [DW-1:0] exp_v;
    @(negedge clk);
    check({tag, ".idle_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    start   = 1'b1;
    bias_in = DW'(bias);
    exp_q.push_back(model(bias));
    @(negedge clk);
    start   = 1'b0;
    bias_in = '0;
    check({tag, ".acc_busy"}, 32'(busy), 32'd1);
    if (start_busy) begin
      start   = 1'b1;
      bias_in = 8'h70;
      @(negedge clk);
      start   = 1'b0;
      bias_in = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          in_valid  = 1'b0;
          data_in   = DW'($urandom_range(0, 255));
          weight_in = DW'($urandom_range(0, 255));
          @(negedge clk);
        end
      end
      in_valid  = 1'b1;
      data_in   = g_d[i];
      weight_in = g_w[i];
      check({tag, ".pair_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, ".latency_valid"}, 32'(sum_valid), 32'd1);
    check({tag, ".out_ready"}, 32'(in_ready), 32'd0);
    exp_v = exp_q[0];
    for (int k = 0; k < hold; k++) begin
      check({tag, ".hold_valid"}, 32'(sum_valid), 32'd1);
      check({tag, ".hold_sum"}, 32'(sum_out), 32'(exp_v));
      @(negedge clk);
    end
    sum_ready = 1'b1;
    if (start_ack) begin
      start   = 1'b1;
      bias_in = 8'h70;
    end
    check({tag, ".sum_out"}, 32'(sum_out), 32'(exp_q.pop_front()));
    @(negedge clk);
    sum_ready = 1'b0;
    start     = 1'b0;
    bias_in   = '0;
    check({tag, ".valid_drop"}, 32'(sum_valid), 32'd0);
    check({tag, ".back_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias_in = '0; in_valid = 1'b0;
    data_in = '0; weight_in = '0; sum_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.sum_valid", 32'(sum_valid), 32'd0);
    check("rst.sum_out", 32'(sum_out), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    set_pairs(16, 16);
    run_neuron("unity", 0, 1'b0, 0, 1'b0, 1'b0);
    check("unity.value", 32'(model(0)), 32'hC0);
    set_pairs(127, 127);
    run_neuron("sat_pos", 0, 1'b0, 0, 1'b0, 1'b0);
    set_pairs(-128, 127);
    run_neuron("sat_neg", 0, 1'b0, 0, 1'b0, 1'b0);
    set_pairs(0, 37);
    run_neuron("bias16", 16, 1'b0, 0, 1'b0, 1'b0);
    run_neuron("zero", 0, 1'b0, 0, 1'b0, 1'b0);
    set_pairs(16, 16);
    run_neuron("gaps", 0, 1'b1, 0, 1'b0, 1'b0);
    run_neuron("backpressure", 0, 1'b0, 10, 1'b0, 1'b0);
    run_neuron("start_busy", 0, 1'b0, 0, 1'b1, 1'b1);
    // A start that coincided with the handshake must not have launched a neuron.
    @(negedge clk);
    check("start_ack.still_idle", 32'(busy), 32'd0);
    check("start_ack.no_result", 32'(sum_valid), 32'd0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        g_d[i] = DW'($urandom_range(0, 255));
        g_w[i] = DW'($urandom_range(0, 255));
      end
      run_neuron("random", int'($signed(DW'($urandom_range(0, 255)))), 1'b1, 2, 1'b0, 1'b0);
    end

    // Abort a neuron halfway with reset, then check for residue.
    set_pairs(100, 100);
    @(negedge clk);
    start = 1'b1; bias_in = 8'h30;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; data_in = g_d[i]; weight_in = g_w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort.in_ready", 32'(in_ready), 32'd0);
    check("abort.sum_valid", 32'(sum_valid), 32'd0);
    check("abort.sum_out", 32'(sum_out), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    set_pairs(16, 16);
    run_neuron("after_abort", 0, 1'b0, 0, 1'b0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
